mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Memory-stage access controller of the pipelined CPU. Sits between the EX/MEM segment and the MEM/WB segment.
//  Turns MemReadM/MemWriteM into a ready-handshake transaction on the data memory and stalls the pipeline until done.
//  Supplies ReadDataM to the MEM/WB segment. Rejects misaligned or out-of-range accesses via MemErrM.
// PARAMETERS
//  DATA_W     32            data/address width
//  TIMEOUT    16            max REQ cycles without dmem_ready before abort (>=2)
//  ADDR_BASE  32'h0000_0000 lowest legal byte address
//  ADDR_LIMIT 32'h0000_03FC highest legal word address (inclusive)
// PORTS
//  clk          in   1       single clock, all state updates on posedge
//  rst          in   1       synchronous, active-high reset
//  MemReadM     in   1       load in M stage
//  MemWriteM    in   1       store in M stage (MemReadM&MemWriteM is illegal -> treated as error)
//  FlushM       in   1       kill the M-stage instruction (honoured in IDLE only)
//  ALUOutM      in   DATA_W  byte address
//  WriteDataM   in   DATA_W  store data
//  dmem_req     out  1       request valid to data memory
//  dmem_we      out  1       1=write, 0=read
//  dmem_addr    out  DATA_W  latched address
//  dmem_wdata   out  DATA_W  latched store data
//  dmem_ready   in   1       memory completes request this cycle
//  dmem_rdata   in   DATA_W  read data, valid with dmem_ready on reads
//  ReadDataM    out  DATA_W  load result to MEM/WB segment
//  StallM       out  1       freeze PC/IF/ID/EX/MEM segments
//  MemErrM      out  1       one-cycle pulse: access aborted
// BEHAVIOUR
//  Reset: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, ReadDataM=0, MemErrM=0, counter=0.
//  StallM is combinational and therefore also 0 in reset.
//  acc = (MemReadM|MemWriteM) & ~FlushM
//  bad = ALUOutM[1:0]!=0 | ALUOutM<ADDR_BASE | ALUOutM>ADDR_LIMIT | (MemReadM&MemWriteM)
//  IDLE:
//    - acc&~bad -> REQ; latch addr/wdata/we; StallM=1 this cycle.
//    - acc&bad -> ERR; StallM=1 this cycle; no request issued.
//    - Otherwise stay in IDLE, StallM=0. dmem_ready is ignored in IDLE.
//  REQ:
//    - dmem_req=1; dmem_addr/dmem_wdata/dmem_we are held stable; StallM=1.
//    - dmem_ready -> DONE. On a read, capture ReadDataM<=dmem_rdata; on a write, ReadDataM is unchanged.
//    - Otherwise counter++. If counter==TIMEOUT-1 with no ready -> ERR, dmem_req drops at the next edge.
//    - Ready and timeout in the same cycle: ready wins.
//    - FlushM is ignored in REQ; in-flight transactions always complete or time out.
//  DONE:
//    - dmem_req=0, StallM=0; the pipeline advances this cycle; ReadDataM valid.
//    - Next state is always IDLE. The same instruction is never re-issued, and acc is not sampled in DONE.
//  ERR:
//    - MemErrM=1, StallM=0, ReadDataM<=0, dmem_req=0; next state IDLE.
//  Counter clears on every entry to REQ.
//  Latency: zero-wait memory gives StallM high for 2 cycles (IDLE, REQ) and release in DONE.
//  An access therefore occupies N+2 cycles, where N = REQ cycles.
//  ReadDataM holds its value from DONE until the next completed read, ERR, or reset.
//  Reset mid-transaction: back to IDLE at the reset edge, dmem_req=0; no MemErrM pulse.
// STRUCTURE
//  Package mem_stage_pkg:
//    - typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} mem_state_t
//    - ADDR_ALIGN_MASK = 2'b11
//  Sub-module mem_timeout_counter:
//    - $clog2(TIMEOUT) bits; inputs clr, en; output expired.
//  FSM, latch registers and the range check live in the top module.
// TESTING
//  1 Load addr 0x10, dmem_ready on first REQ cycle, rdata 0xDEADBEEF.
//    -> StallM=1,1,0; dmem_req one cycle; ReadDataM=0xDEADBEEF in DONE.
//  2 Store addr 0x20, data 0x12345678, ready after 3 REQ cycles.
//    -> dmem_we=1, addr/wdata stable all 3 cycles; StallM 4 cycles; ReadDataM unchanged.
//  3 Load addr 0x13 (misaligned); separately a load at 0x400 (> limit).
//    -> no dmem_req; StallM 1 cycle; MemErrM pulse; ReadDataM=0.
//  4 Load, dmem_ready never asserted.
//    -> dmem_req high exactly TIMEOUT cycles (16); then MemErrM pulse; back in IDLE.
//  5 Load plus FlushM in IDLE -> no request. FlushM raised during REQ -> transaction still completes to DONE.
//  6 rst asserted in the 2nd REQ cycle -> next edge: IDLE, dmem_req=0, ReadDataM=0, MemErrM=0.
//    -> After reset release, a new load at 0x4 completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
//  Shared types and constants for the memory-stage access controller.
//  - mem_state_t     : controller FSM states
//  - ADDR_ALIGN_MASK : low address bits that must be zero for a word access
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } mem_state_t;

    localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_timeout_counter.sv
// ---------------------------------------------------------------------------
// mem_timeout_counter
//  Counts REQ cycles spent waiting for the data memory. expired is high while
//  the count sits at TIMEOUT-1, i.e. in the last REQ cycle we are willing to
//  wait for dmem_ready.
//  Ports:
//    clk     in  1  clock
//    rst     in  1  synchronous active-high reset
//    clr     in  1  clear the count (entry into REQ)
//    en      in  1  advance the count by one
//    expired out 1  count == TIMEOUT-1
// ---------------------------------------------------------------------------
module mem_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Enough bits to hold 0 .. TIMEOUT-1.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
//  Memory-stage access controller. Converts MemReadM/MemWriteM from the
//  EX/MEM segment into a ready-handshake transaction on the data memory,
//  stalls the pipeline until the transaction is done, supplies ReadDataM to
//  MEM/WB, and rejects misaligned / out-of-range / read+write accesses with a
//  one-cycle MemErrM pulse.
//  Ports:
//    clk, rst               clock, synchronous active-high reset
//    MemReadM, MemWriteM    load / store request in M stage
//    FlushM                 kill the M-stage instruction (only seen in IDLE)
//    ALUOutM                byte address
//    WriteDataM             store data
//    dmem_req/we/addr/wdata request to data memory (registered)
//    dmem_ready, dmem_rdata completion and read data from data memory
//    ReadDataM              load result
//    StallM                 combinational pipeline freeze
//    MemErrM                one-cycle abort pulse
// ---------------------------------------------------------------------------
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter int                 TIMEOUT    = 16,
    parameter logic [DATA_W-1:0]  ADDR_BASE  = 'h0000_0000,
    parameter logic [DATA_W-1:0]  ADDR_LIMIT = 'h0000_03FC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic              FlushM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              MemErrM
);

    mem_state_t state;
    mem_state_t state_next;

    logic acc;
    logic bad;
    logic misaligned;
    logic below_base;
    logic above_limit;
    logic latch_en;
    logic cnt_en;
    logic expired;

    // Access qualification. The lower-bound test uses the borrow out of a
    // widened subtraction so it stays a real comparison even when ADDR_BASE
    // is zero.
    assign acc         = (MemReadM | MemWriteM) & ~FlushM;
    assign misaligned  = (ALUOutM[1:0] & ADDR_ALIGN_MASK) != 2'b00;
    assign below_base  = 1'(({1'b0, ALUOutM} - {1'b0, ADDR_BASE}) >> DATA_W);
    assign above_limit = ALUOutM > ADDR_LIMIT;
    assign bad         = misaligned | below_base | above_limit | (MemReadM & MemWriteM);

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (latch_en),
        .en      (cnt_en),
        .expired (expired)
    );

    // Next-state and combinational outputs. Ready beats timeout in REQ
    // because the ready test is taken first.
    always_comb begin
        state_next = state;
        StallM     = 1'b0;
        latch_en   = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    StallM = 1'b1;
                    if (bad) begin
                        state_next = ERR;
                    end else begin
                        state_next = REQ;
                        latch_en   = 1'b1;
                    end
                end
            end
            REQ: begin
                StallM = 1'b1;
                if (dmem_ready) begin
                    state_next = DONE;
                end else begin
                    cnt_en = 1'b1;
                    if (expired) begin
                        state_next = ERR;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs. dmem_req and MemErrM are decoded from
    // the next state so they are glitch-free registers that line up exactly
    // with the REQ and ERR states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            ReadDataM  <= '0;
            MemErrM    <= 1'b0;
        end else begin
            state    <= state_next;
            dmem_req <= (state_next == REQ);
            MemErrM  <= (state_next == ERR);
            if (latch_en) begin
                dmem_addr  <= ALUOutM;
                dmem_wdata <= WriteDataM;
                dmem_we    <= MemWriteM;
            end
            if ((state == REQ) && dmem_ready && !dmem_we) begin
                ReadDataM <= dmem_rdata;
            end else if (state == ERR) begin
                ReadDataM <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_ctrl
//  Directed bench for mem_stage_ctrl. Each accepted/rejected access pushes
//  its expected outcome (error flag, ReadDataM after completion) into a
//  scoreboard queue; a monitor pops and compares when the DUT completes
//  (cycle after dmem_req&dmem_ready) or aborts (MemErrM).
// ---------------------------------------------------------------------------
module tb_mem_stage_ctrl;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        FlushM = 1'b0;
    logic [31:0] ALUOutM = '0;
    logic [31:0] WriteDataM = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MemErrM;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_rdata = '0;
    int          reqCycles;

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .DATA_W     (32),
        .TIMEOUT    (16),
        .ADDR_BASE  (32'h0000_0000),
        .ADDR_LIMIT (32'h0000_03FC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .FlushM     (FlushM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MemErrM    (MemErrM)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic fl,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic rdy, input logic [31:0] rdata);
        MemReadM   = rd;
        MemWriteM  = wr;
        FlushM     = fl;
        ALUOutM    = addr;
        WriteDataM = wdata;
        dmem_ready = rdy;
        dmem_rdata = rdata;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpect(input logic err, input logic [31:0] rdata);
        exp_t e;
        e.err   = err;
        e.rdata = rdata;
        sbq.push_back(e);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        logic doneNext;
        exp_t e;
        doneNext = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                doneNext = 1'b0;
            end else begin
                if (doneNext || MemErrM) begin
                    if (sbq.size() == 0) begin
                        checkOutput("sb_nonempty", 32'(sbq.size()), 32'd1);
                    end else begin
                        e = sbq.pop_front();
                        checkOutput("sb_err", {31'd0, MemErrM}, {31'd0, e.err});
                        if (!e.err) begin
                            checkOutput("sb_rdata", ReadDataM, e.rdata);
                            checkOutput("sb_stall_done", {31'd0, StallM}, 32'd0);
                        end
                    end
                end
                doneNext = dmem_req && dmem_ready;
            end
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (2) nextCycle();
        checkOutput("rst_req",   {31'd0, dmem_req}, 32'd0);
        checkOutput("rst_we",    {31'd0, dmem_we},  32'd0);
        checkOutput("rst_addr",  dmem_addr,  32'd0);
        checkOutput("rst_wdata", dmem_wdata, 32'd0);
        checkOutput("rst_rdata", ReadDataM,  32'd0);
        checkOutput("rst_err",   {31'd0, MemErrM}, 32'd0);
        checkOutput("rst_stall", {31'd0, StallM},  32'd0);
        rst = 1'b0;
        nextCycle();

        // ---------------- 1: zero-wait load ----------------
        applyStimulus(1, 0, 0, 32'h10, 32'h0, 0, 32'h0);
        checkOutput("t1_stall_idle", {31'd0, StallM}, 32'd1);
        model_rdata = 32'hDEADBEEF;
        pushExpect(1'b0, model_rdata);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 32'hDEADBEEF);
        checkOutput("t1_req",   {31'd0, dmem_req}, 32'd1);
        checkOutput("t1_stall_req", {31'd0, StallM}, 32'd1);
        checkOutput("t1_addr",  dmem_addr, 32'h10);
        checkOutput("t1_we",    {31'd0, dmem_we}, 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkOutput("t1_req_done", {31'd0, dmem_req}, 32'd0);
        checkOutput("t1_stall_done", {31'd0, StallM}, 32'd0);
        checkOutput("t1_rdata", ReadDataM, 32'hDEADBEEF);
        nextCycle();
        checkOutput("t1_idle_req", {31'd0, dmem_req}, 32'd0);

        // ---------------- 2: store with 3 REQ cycles ----------------
        applyStimulus(0, 1, 0, 32'h20, 32'h12345678, 0, 32'h0);
        checkOutput("t2_stall_idle", {31'd0, StallM}, 32'd1);
        pushExpect(1'b0, model_rdata);
        for (int i = 1; i <= 3; i++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 32'h0, 32'h0, (i == 3), 32'h55AA55AA);
            checkOutput("t2_req",   {31'd0, dmem_req}, 32'd1);
            checkOutput("t2_we",    {31'd0, dmem_we}, 32'd1);
            checkOutput("t2_addr",  dmem_addr, 32'h20);
            checkOutput("t2_wdata", dmem_wdata, 32'h12345678);
            checkOutput("t2_stall", {31'd0, StallM}, 32'd1);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkOutput("t2_stall_done", {31'd0, StallM}, 32'd0);
        checkOutput("t2_rdata", ReadDataM, 32'hDEADBEEF);
        nextCycle();

        // ---------------- 3: misaligned and out-of-range loads ----------------
        applyStimulus(1, 0, 0, 32'h13, 32'h0, 0, 32'h0);
        checkOutput("t3a_stall", {31'd0, StallM}, 32'd1);
        model_rdata = 32'h0;
        pushExpect(1'b1, model_rdata);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkOutput("t3a_err",   {31'd0, MemErrM}, 32'd1);
        checkOutput("t3a_req",   {31'd0, dmem_req}, 32'd0);
        checkOutput("t3a_stall_err", {31'd0, StallM}, 32'd0);
        nextCycle();
        checkOutput("t3a_err_pulse", {31'd0, MemErrM}, 32'd0);
        checkOutput("t3a_rdata", ReadDataM, 32'h0);

        // Highest legal word: accepted.
        applyStimulus(1, 0, 0, 32'h3FC, 32'h0, 0, 32'h0);
        model_rdata = 32'hA5A50001;
        pushExpect(1'b0, model_rdata);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 32'hA5A50001);
        checkOutput("t3_limit_req", {31'd0, dmem_req}, 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkOutput("t3_limit_rdata", ReadDataM, 32'hA5A50001);
        nextCycle();

        // One word past the limit: rejected, ReadDataM cleared.
        applyStimulus(1, 0, 0, 32'h400, 32'h0, 0, 32'h0);
        checkOutput("t3b_stall", {31'd0, StallM}, 32'd1);
        model_rdata = 32'h0;
        pushExpect(1'b1, model_rdata);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkOutput("t3b_err", {31'd0, MemErrM}, 32'd1);
        checkOutput("t3b_req", {31'd0, dmem_req}, 32'd0);
        nextCycle();
        checkOutput("t3b_rdata", ReadDataM, 32'h0);

        // Read and write together: rejected.
        applyStimulus(1, 1, 0, 32'h40, 32'h0, 0, 32'h0);
        pushExpect(1'b1, model_rdata);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkOutput("t3c_err", {31'd0, MemErrM}, 32'd1);
        checkOutput("t3c_req", {31'd0, dmem_req}, 32'd0);
        nextCycle();

        // ---------------- 4: timeout ----------------
        applyStimulus(1, 0, 0, 32'h8, 32'h0, 0, 32'h0);
        pushExpect(1'b1, model_rdata);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        reqCycles = 0;
        while (dmem_req && reqCycles < 40) begin
            reqCycles++;
            nextCycle();
        end
        checkOutput("t4_req_cycles", 32'(reqCycles), 32'd16);
        checkOutput("t4_err", {31'd0, MemErrM}, 32'd1);
        checkOutput("t4_stall_err", {31'd0, StallM}, 32'd0);
        nextCycle();
        checkOutput("t4_err_pulse", {31'd0, MemErrM}, 32'd0);
        checkOutput("t4_idle_stall", {31'd0, StallM}, 32'd0);
        checkOutput("t4_rdata", ReadDataM, 32'h0);

        // ---------------- 5: flush ----------------
        applyStimulus(1, 0, 1, 32'h10, 32'h0, 0, 32'h0);
        checkOutput("t5_flush_stall", {31'd0, StallM}, 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkOutput("t5_flush_req", {31'd0, dmem_req}, 32'd0);
        applyStimulus(1, 0, 0, 32'h14, 32'h0, 0, 32'h0);
        model_rdata = 32'hCAFE0005;
        pushExpect(1'b0, model_rdata);
        nextCycle();
        applyStimulus(0, 0, 1, 32'h0, 32'h0, 0, 32'h0);
        checkOutput("t5_req1", {31'd0, dmem_req}, 32'd1);
        nextCycle();
        applyStimulus(0, 0, 1, 32'h0, 32'h0, 1, 32'hCAFE0005);
        checkOutput("t5_req2", {31'd0, dmem_req}, 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkOutput("t5_rdata", ReadDataM, 32'hCAFE0005);
        nextCycle();

        // ---------------- 6: reset mid-transaction ----------------
        applyStimulus(1, 0, 0, 32'h18, 32'h0, 0, 32'h0);
        pushExpect(1'b0, 32'h77777777);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        nextCycle();
        checkOutput("t6_req2", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        sbq.delete();
        model_rdata = 32'h0;
        nextCycle();
        checkOutput("t6_req",   {31'd0, dmem_req}, 32'd0);
        checkOutput("t6_rdata", ReadDataM, 32'h0);
        checkOutput("t6_err",   {31'd0, MemErrM}, 32'd0);
        checkOutput("t6_stall", {31'd0, StallM}, 32'd0);
        rst = 1'b0;
        nextCycle();
        applyStimulus(1, 0, 0, 32'h4, 32'h0, 0, 32'h0);
        model_rdata = 32'h0BADF00D;
        pushExpect(1'b0, model_rdata);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 32'h0BADF00D);
        checkOutput("t6_addr", dmem_addr, 32'h4);
        nextCycle();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        checkOutput("t6_rdata_new", ReadDataM, 32'h0BADF00D);
        nextCycle();
        nextCycle();

        checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
